// File: rtl/alu_frame_pkg.sv
// Shared definitions for the framed UART/ALU controller.
// Contents:
//   - opcode encodings (6-bit, matched against the low NB_CODE bits of the opcode byte)
//   - receive FSM state encoding (3 bits) and transmit FSM state encoding (1 bit)
//   - frame_checksum(): XOR of operand A, operand B and opcode
package alu_frame_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_OP   = 3'd2,
    ST_CHK  = 3'd3,
    ST_EXEC = 3'd4
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // Operates on a 32-bit container so any byte width up to 32 can share it;
  // callers truncate the result back to their data width.
  function automatic logic [31:0] frame_checksum(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input logic [31:0] op);
    return a ^ b ^ op;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding ALU results until the transmitter takes them.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wr_data   write request and data (ignored when full unless popping)
//   pop, rd_data    read request; rd_data always shows the head entry
//   full, empty     occupancy flags
//   count           registered occupancy, 0..FIFO_DEPTH
module sync_fifo #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [NB_DATA-1:0]            wr_data,
  input  logic                          pop,
  output logic [NB_DATA-1:0]            rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [NB_DATA-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_reg;
  logic [AW:0]        rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // addresses with differing wrap bits mean full.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed UART/ALU controller: assembles 4-byte frames (A, B, opcode, XOR
// checksum), validates and executes them, queues results and feeds the UART
// transmitter one byte per start/done handshake.
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_rx_done, i_rx_data  received-byte strobe and byte
//   i_tx_done             transmitter finished the current byte
//   o_tx_start, o_tx_data start pulse and byte (held until the next start)
//   o_err_cnt             saturating count of rejected/timed-out frames
//   o_ovf                 sticky: a valid result was dropped on a full FIFO
//   o_fifo_count          result FIFO occupancy
module alu_frame_ctrl #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_CODE        = 6,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned NB_ERR         = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_rx_done,
  input  logic [NB_DATA-1:0]          i_rx_data,
  input  logic                        i_tx_done,
  output logic                        o_tx_start,
  output logic [NB_DATA-1:0]          o_tx_data,
  output logic [NB_ERR-1:0]           o_err_cnt,
  output logic                        o_ovf,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  import alu_frame_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t            rx_state_reg;
  tx_state_t            tx_state_reg;
  logic [NB_DATA-1:0]   a_reg, b_reg, op_reg, chk_reg;
  logic [TW-1:0]        timer_reg;
  logic [NB_ERR-1:0]    err_cnt_reg;
  logic [NB_ERR-1:0]    err_cnt_next;
  logic                 ovf_reg;
  logic                 tx_start_reg;
  logic [NB_DATA-1:0]   tx_data_reg;

  logic [NB_CODE-1:0]   code;
  logic [NB_DATA-1:0]   alu_result;
  logic                 op_valid;
  logic                 chk_ok;
  logic                 frame_ok;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NB_DATA-1:0]   fifo_rd_data;

  assign code     = op_reg[NB_CODE-1:0];
  assign chk_ok   = (NB_DATA'(frame_checksum(32'(a_reg), 32'(b_reg), 32'(op_reg))) == chk_reg);
  assign frame_ok = chk_ok && op_valid;

  // Saturating increment shared by the reject and timeout paths.
  assign err_cnt_next = (err_cnt_reg == '1) ? err_cnt_reg : err_cnt_reg + NB_ERR'(1);

  always_comb begin
    alu_result = '0;
    op_valid   = 1'b1;
    case (code)
      NB_CODE'(OP_ADD): alu_result = a_reg + b_reg;
      NB_CODE'(OP_SUB): alu_result = a_reg - b_reg;
      NB_CODE'(OP_AND): alu_result = a_reg & b_reg;
      NB_CODE'(OP_OR):  alu_result = a_reg | b_reg;
      NB_CODE'(OP_XOR): alu_result = a_reg ^ b_reg;
      NB_CODE'(OP_NOR): alu_result = ~(a_reg | b_reg);
      NB_CODE'(OP_SRA): alu_result = (32'(b_reg) >= NB_DATA) ? {NB_DATA{a_reg[NB_DATA-1]}}
                                                             : NB_DATA'($signed(a_reg) >>> b_reg);
      NB_CODE'(OP_SRL): alu_result = (32'(b_reg) >= NB_DATA) ? '0 : (a_reg >> b_reg);
      default:          op_valid   = 1'b0;
    endcase
  end

  assign fifo_pop  = (tx_state_reg == TX_IDLE) && !fifo_empty;
  assign fifo_push = (rx_state_reg == ST_EXEC) && frame_ok;

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset),
    .push    (fifo_push),
    .wr_data (alu_result),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  // Receive / execute FSM.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_state_reg <= ST_A;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      chk_reg      <= '0;
      timer_reg    <= '0;
      err_cnt_reg  <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      case (rx_state_reg)
        ST_A: begin
          timer_reg <= '0;
          if (i_rx_done) begin
            a_reg        <= i_rx_data;
            rx_state_reg <= ST_B;
          end
        end
        ST_B, ST_OP, ST_CHK: begin
          if (i_rx_done) begin
            // A byte arriving on the timeout cycle still counts.
            timer_reg <= '0;
            case (rx_state_reg)
              ST_B:    begin b_reg   <= i_rx_data; rx_state_reg <= ST_OP;   end
              ST_OP:   begin op_reg  <= i_rx_data; rx_state_reg <= ST_CHK;  end
              default: begin chk_reg <= i_rx_data; rx_state_reg <= ST_EXEC; end
            endcase
          end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            timer_reg    <= '0;
            err_cnt_reg  <= err_cnt_next;
            rx_state_reg <= ST_A;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_EXEC: begin
          timer_reg <= '0;
          if (!frame_ok) begin
            err_cnt_reg <= err_cnt_next;
          end else if (fifo_full && !fifo_pop) begin
            ovf_reg <= 1'b1;
          end
          // Back-to-back frames: a byte here is already operand A.
          if (i_rx_done) begin
            a_reg        <= i_rx_data;
            rx_state_reg <= ST_B;
          end else begin
            rx_state_reg <= ST_A;
          end
        end
        default: rx_state_reg <= ST_A;
      endcase
    end
  end

  // Transmit handshake FSM.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state_reg <= TX_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      case (tx_state_reg)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_data_reg  <= fifo_rd_data;
            tx_start_reg <= 1'b1;
            tx_state_reg <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (i_tx_done) tx_state_reg <= TX_IDLE;
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign o_tx_start = tx_start_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_err_cnt  = err_cnt_reg;
  assign o_ovf      = ovf_reg;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Self-checking bench for alu_frame_ctrl: expected results are queued when a
// frame is sent and compared when the DUT raises o_tx_start.
module tb_alu_frame_ctrl;

  localparam int NB_DATA        = 8;
  localparam int NB_CODE        = 6;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int NB_ERR         = 8;
  localparam int NB_CNT         = $clog2(FIFO_DEPTH) + 1;

  logic                 i_clk     = 1'b0;
  logic                 i_reset   = 1'b1;
  logic                 i_rx_done = 1'b0;
  logic [NB_DATA-1:0]   i_rx_data = '0;
  logic                 i_tx_done = 1'b0;
  logic                 o_tx_start;
  logic [NB_DATA-1:0]   o_tx_data;
  logic [NB_ERR-1:0]    o_err_cnt;
  logic                 o_ovf;
  logic [NB_CNT-1:0]    o_fifo_count;

  alu_frame_ctrl #(
    .NB_DATA        (NB_DATA),
    .NB_CODE        (NB_CODE),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_ERR         (NB_ERR)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_err_cnt    (o_err_cnt),
    .o_ovf        (o_ovf),
    .o_fifo_count (o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  int unsigned last_byte_cyc = 0;
  int unsigned last_start_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned n_starts = 0;
  int          wait_cnt = 0;
  bit          started = 0, tx_auto = 1, tx_busy = 0, done_seen = 0;
  bit          done_nonempty = 0, prev_valid = 0;
  logic [7:0]  prev_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU; shifts are done one bit at a time.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [7:0] r;
    r = a;
    case (op[5:0])
      6'h20: r = a + b;
      6'h22: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: for (int i = 0; i < 8; i++) if (i < b) r = {r[7], r[7:1]};
      6'h02: for (int i = 0; i < 8; i++) if (i < b) r = {1'b0, r[7:1]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_done     = 1'b1;
    i_rx_data     = b;
    last_byte_cyc = cyc;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] chk, input bit expect_push);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    if (expect_push) exp_q.push_back(alu_model(a, b, op));
    send_byte(chk);
  endtask

  task automatic send_good(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_frame(a, b, op, a ^ b ^ op, 1'b1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check_val("drain_in_budget", 32'(n < budget), 1);
    wait_cycles(3);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #3;
    i_reset   = 1'b0;
    i_rx_done = 1'b0;
    #1;
    check_val("rst_tx_start", o_tx_start, 0);
    check_val("rst_tx_data", o_tx_data, 0);
    check_val("rst_err_cnt", o_err_cnt, 0);
    check_val("rst_ovf", o_ovf, 0);
    check_val("rst_fifo_count", o_fifo_count, 0);
    exp_q.delete();
    wait_cycles(2);
    #2 i_reset = 1'b1;
    started = 1'b1;
  endtask

  // Monitor and transmitter model: compares each started byte with the
  // scoreboard and answers with i_tx_done a few cycles later when enabled.
  always @(negedge i_clk) begin
    if (!i_reset || !started) begin
      i_tx_done  = 1'b0;
      tx_busy    = 1'b0;
      done_seen  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      i_tx_done = 1'b0;
      if (o_tx_start) begin
        n_starts++;
        last_start_cyc = cyc;
        check_val("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check_val("tx_data", o_tx_data, mon_exp);
          $display("tx byte 0x%02h (expected 0x%02h) at cycle %0d", o_tx_data, mon_exp, cyc);
        end
        if (done_seen) begin
          if (done_nonempty) check_val("done_to_start", cyc - done_cyc, 2);
          else               check_val("done_to_start_min", 32'((cyc - done_cyc) >= 2), 1);
          done_seen = 1'b0;
        end
        tx_busy  = 1'b1;
        wait_cnt = 2;
      end else begin
        if (prev_valid) check_val("tx_data_stable", o_tx_data, prev_data);
        if (tx_busy && tx_auto) begin
          if (wait_cnt == 0) begin
            i_tx_done     = 1'b1;
            tx_busy       = 1'b0;
            done_seen     = 1'b1;
            done_cyc      = cyc;
            done_nonempty = (o_fifo_count != 0);
          end else begin
            wait_cnt--;
          end
        end
      end
      prev_data  = o_tx_data;
      prev_valid = 1'b1;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s0;
    do_reset();

    // Basic ADD with latency: push visible in N+2, start in N+3.
    send_frame(8'h05, 8'h03, 8'h20, 8'h26, 1'b1);
    @(negedge i_clk);
    check_val("fifo_cnt_exec", o_fifo_count, 0);
    @(negedge i_clk);
    check_val("fifo_cnt_push", o_fifo_count, 1);
    wait_drain(50);
    check_val("start_latency", last_start_cyc - last_byte_cyc, 3);
    check_val("err_after_add", o_err_cnt, 0);

    // Shifts, including the shift-amount boundary, and wrap cases.
    send_frame(8'h80, 8'h09, 8'h03, 8'h8A, 1'b1);
    send_frame(8'h80, 8'h01, 8'h02, 8'h83, 1'b1);
    send_good(8'h80, 8'h08, 8'h02);
    send_good(8'h40, 8'h07, 8'h03);
    send_good(8'h03, 8'h05, 8'h22);
    send_good(8'hF0, 8'h20, 8'h20);
    send_good(8'h0F, 8'h30, 8'h27);
    send_good(8'h3C, 8'h0F, 8'h26);
    wait_drain(200);
    check_val("err_after_ops", o_err_cnt, 0);

    // Rejected frames.
    s0 = n_starts;
    send_frame(8'h05, 8'h03, 8'h20, 8'h00, 1'b0);
    wait_cycles(10);
    check_val("bad_chk_no_start", n_starts, s0);
    check_val("bad_chk_err", o_err_cnt, 1);
    send_frame(8'h05, 8'h03, 8'h3F, 8'h39, 1'b0);
    wait_cycles(10);
    check_val("bad_op_no_start", n_starts, s0);
    check_val("bad_op_err", o_err_cnt, 2);

    // Timeout after two bytes.
    do_reset();
    send_byte(8'h05);
    send_byte(8'h03);
    repeat (TIMEOUT_CYCLES - 1) @(posedge i_clk);
    #1;
    check_val("timeout_not_yet", o_err_cnt, 0);
    @(posedge i_clk); #1;
    check_val("timeout_err", o_err_cnt, 1);
    send_frame(8'h05, 8'h03, 8'h20, 8'h26, 1'b1);
    wait_drain(50);
    check_val("after_timeout_err", o_err_cnt, 1);

    // Byte on the would-be timeout cycle is accepted.
    send_byte(8'h21);
    send_byte(8'h12);
    repeat (TIMEOUT_CYCLES - 2) @(posedge i_clk);
    exp_q.push_back(alu_model(8'h21, 8'h12, 8'h20));
    send_byte(8'h20);
    send_byte(8'h21 ^ 8'h12 ^ 8'h20);
    wait_drain(50);
    check_val("edge_rx_wins_err", o_err_cnt, 1);

    // FIFO fill with the transmitter stalled, then overflow.
    tx_auto = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 5; i++) send_good(8'(i + 1), 8'h10, 8'h20);
    wait_cycles(6);
    check_val("fill_count", o_fifo_count, 4);
    check_val("fill_no_ovf", o_ovf, 0);
    check_val("fill_one_start", n_starts - s0, 1);
    send_frame(8'h77, 8'h01, 8'h20, 8'h77 ^ 8'h01 ^ 8'h20, 1'b0);
    wait_cycles(6);
    check_val("ovf_set", o_ovf, 1);
    check_val("ovf_count", o_fifo_count, 4);
    tx_auto = 1'b1;
    wait_drain(300);
    check_val("drain_count", o_fifo_count, 0);
    check_val("drain_starts", n_starts - s0, 5);
    check_val("ovf_sticky", o_ovf, 1);

    // Reset while transmitting, with a queued result and a partial frame.
    tx_auto = 1'b0;
    send_good(8'h11, 8'h22, 8'h25);
    wait_cycles(6);
    send_good(8'h44, 8'h05, 8'h20);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_cycles(2);
    check_val("pre_rst_count", o_fifo_count, 1);
    do_reset();
    tx_auto = 1'b1;
    s0 = n_starts;
    send_good(8'h07, 8'h09, 8'h20);
    wait_drain(50);
    check_val("post_rst_starts", n_starts - s0, 1);
    check_val("post_rst_err", o_err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_frame_ctrl.md
# alu_frame_ctrl

Framed, buffered successor to the single-byte UART/ALU interface. It sits between the UART receiver/transmitter pair and drives the transmitter directly. It assembles 4-byte command frames from the receiver (operand A, operand B, opcode, XOR checksum), validates them, and executes the ALU operation. Results are queued in a parametrised FIFO and handed to the transmitter one byte at a time under a start/done handshake. It also provides frame timeout recovery and error/overflow reporting.

## Interface
- NB_DATA, 8, operand/result/UART byte width
- NB_CODE, 6, opcode width (low NB_CODE bits of opcode byte)
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1_000_000, max idle clocks between bytes of one frame
- NB_ERR, 8, error counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  one-cycle pulse, received byte valid
- i_rx_data  in  NB_DATA  received byte, valid with i_rx_done
- i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
- o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit, held stable from o_tx_start until i_tx_done
- o_err_cnt  out  NB_ERR  saturating count of rejected frames (checksum, opcode, timeout)
- o_ovf  out  1  sticky: a valid result was dropped on full FIFO
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset (i_reset low, async): all outputs 0, RX FSM in ST_A, TX FSM in TX_IDLE, FIFO empty, timeout counter 0.
- RX FSM: ST_A → ST_B → ST_OP → ST_CHK → ST_EXEC → ST_A. Each receive state latches i_rx_data on i_rx_done and advances.
- ST_EXEC lasts exactly one cycle. Checksum valid iff A ^ B ^ OP == CHK. Opcode valid iff in the opcode set.
- Valid frame: result pushed. If the FIFO is full with no simultaneous pop, the result is dropped and o_ovf is set.
- Invalid frame: nothing pushed; o_err_cnt +1, saturating at all-ones.
- i_rx_done during ST_EXEC is taken as byte A of the next frame; next state is ST_B.
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- ADD/SUB wrap modulo 2^NB_DATA.
- Shifts: A shifted by unsigned B. If B ≥ NB_DATA, SRL gives 0 and SRA gives all copies of A's MSB.
- Timeout: in ST_B/ST_OP/ST_CHK the counter increments each cycle without i_rx_done and clears on i_rx_done. On reaching TIMEOUT_CYCLES: go to ST_A, discard partial frame, o_err_cnt +1. An i_rx_done in that same cycle wins (byte accepted, no timeout). Counter held at 0 in ST_A/ST_EXEC.
- TX FSM, TX_IDLE: when the FIFO is non-empty, pop the head into o_tx_data, pulse o_tx_start, go to TX_BUSY.
- TX FSM, TX_BUSY: wait for i_tx_done, then TX_IDLE. i_tx_done in TX_IDLE is ignored.

## Timing
- All outputs registered.
- Checksum i_rx_done in cycle N → ST_EXEC in N+1 → push visible (o_fifo_count) in N+2 → o_tx_start high in N+3 (TX idle, FIFO previously empty).
- i_tx_done in cycle M with the FIFO non-empty → TX_IDLE in M+1 → next o_tx_start in M+2. Minimum 2 cycles between a done and the next start.
- Simultaneous push and pop on a full FIFO: both happen, count unchanged, no overflow.
- o_tx_data changes only in the cycle o_tx_start is asserted.
- Reset mid-frame or mid-transmit: immediate return to reset state. A byte in flight at the transmitter is not tracked.

## Structure
- Package alu_frame_pkg: opcode localparams, RX state encoding (3 bits), TX state encoding (1 bit), checksum function.
- Sub-module sync_fifo (NB_DATA, FIFO_DEPTH): async active-low reset, push/pop/full/empty/count, wrap-around pointers with extra MSB.
- ALU is a combinational function/always block inside alu_frame_ctrl; no separate module.

## Test plan
- Frame 0x05,0x03,0x20,0x26 → one o_tx_start with o_tx_data=0x08, o_err_cnt=0; check N+3 latency.
- Frame 0x80,0x09,0x03,0x8A (SRA by 9) → 0xFF; frame 0x80,0x01,0x02,0x83 (SRL) → 0x40.
- Bad checksum 0x05,0x03,0x20,0x00 → no o_tx_start, o_err_cnt=1. Opcode 0x3F with correct checksum → o_err_cnt=2.
- Two bytes then TIMEOUT_CYCLES idle → o_err_cnt=1. Next full valid frame executes correctly.
- Five valid frames with i_tx_done withheld (FIFO_DEPTH=4): 1 popped + 4 queued, no overflow. Sixth frame → o_ovf=1. Release i_tx_done pulses → 5 bytes out in order, each ≥2 cycles after done.
- Assert i_reset mid-frame and while TX_BUSY → all outputs 0 immediately. The next frame is processed from byte A.
